// File: rtl/cpu_stat_pkg.sv
// cpu_stat_pkg: shared constants for the CPU statistics display.
//   - Source-select codes for the display mux
//   - Digit count of the seven-segment display
//   - Reset values for the digit enables and segment lines
package cpu_stat_pkg;

  localparam logic [2:0] SRC_LED = 3'd0;
  localparam logic [2:0] SRC_CYC = 3'd1;
  localparam logic [2:0] SRC_UBR = 3'd2;
  localparam logic [2:0] SRC_CBR = 3'd3;
  localparam logic [2:0] SRC_BUB = 3'd4;

  localparam int         NUM_DIGITS = 8;
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  localparam logic [7:0] AN_RST  = 8'hFF;
  localparam logic [7:0] SEG_RST = 8'hFF;

  // One-cold digit enable for the given digit number
  function automatic logic [7:0] digit_enable(input logic [2:0] digit);
    return ~(8'b0000_0001 << digit);
  endfunction

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hexadecimal to seven-segment decoder.
// Ports:
//   nibble  in  4  hex digit value
//   segs    out 7  active-low segments {g,f,e,d,c,b,a}
module hex7seg (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  // Active-low glyph lookup; lowercase b and d keep them distinct from 8 and 0
  always_comb begin
    segs = 7'h7F;
    case (nibble)
      4'h0:    segs = 7'h40;
      4'h1:    segs = 7'h79;
      4'h2:    segs = 7'h24;
      4'h3:    segs = 7'h30;
      4'h4:    segs = 7'h19;
      4'h5:    segs = 7'h12;
      4'h6:    segs = 7'h02;
      4'h7:    segs = 7'h78;
      4'h8:    segs = 7'h00;
      4'h9:    segs = 7'h10;
      4'hA:    segs = 7'h08;
      4'hB:    segs = 7'h03;
      4'hC:    segs = 7'h46;
      4'hD:    segs = 7'h21;
      4'hE:    segs = 7'h06;
      4'hF:    segs = 7'h0E;
      default: segs = 7'h7F;
    endcase
  end

endmodule

// File: rtl/cpu_stat_display.sv
// cpu_stat_display: selects the CPU syscall LED value or one of its
// performance counters and shows it in hex on an 8-digit, time-multiplexed,
// active-low seven-segment display. The displayed value is a snapshot taken
// once per scan frame so a digit sweep never mixes two source values.
//
// Optional feature macro: CPU_STAT_DISPLAY_DP_EN
//   defined     - decimal point lit on the digit whose number equals sel (sel <= 4)
//   not defined - decimal point always dark
//
// Parameters:
//   SCAN_BITS  prescaler width; each digit is lit for 2^SCAN_BITS cycles
// Ports:
//   clk                 in  1   system clock
//   rst                 in  1   synchronous active-low reset
//   led_cpu_enable      in  1   syscall display strobe
//   led_data_in         in  32  syscall display value
//   total_cycles        in  32  CPU cycle counter
//   uncondi_branch_num  in  32  unconditional branch counter
//   condi_branch_num    in  32  conditional branch taken counter
//   bubble_num          in  32  load-use bubble counter
//   sel                 in  3   display source select
//   freeze              in  1   hold the current snapshot
//   an                  out 8   digit enables, active-low, bit i = digit i
//   seg                 out 8   {dp,g,f,e,d,c,b,a}, active-low
//   shown_value         out 32  current snapshot
module cpu_stat_display
  import cpu_stat_pkg::*;
#(
  parameter int SCAN_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_cpu_enable,
  input  logic [31:0] led_data_in,
  input  logic [31:0] total_cycles,
  input  logic [31:0] uncondi_branch_num,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] bubble_num,
  input  logic [2:0]  sel,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [31:0] shown_value
);

  logic [SCAN_BITS-1:0] presc_r;
  logic [2:0]           idx_r;
  logic [31:0]          led_r;
  logic [31:0]          snap_r;
  logic [7:0]           an_r;
  logic [7:0]           seg_r;

  logic                 tick_s;
  logic                 snap_load_s;
  logic [31:0]          src_s;
  logic [3:0]           nibble_s;
  logic [6:0]           hex_s;
  logic                 dp_s;

  assign tick_s      = &presc_r;
  // Last tick of the frame: the sweep is about to restart at digit 0
  assign snap_load_s = tick_s && (idx_r == LAST_DIGIT) && !freeze;
  assign nibble_s    = snap_r[{idx_r, 2'b00} +: 4];

  // Source selection; unused codes show zero
  always_comb begin
    src_s = 32'h0;
    case (sel)
      SRC_LED: src_s = led_r;
      SRC_CYC: src_s = total_cycles;
      SRC_UBR: src_s = uncondi_branch_num;
      SRC_CBR: src_s = condi_branch_num;
      SRC_BUB: src_s = bubble_num;
      default: src_s = 32'h0;
    endcase
  end

  // Decimal point marking the active source
  always_comb begin
    dp_s = 1'b1;
`ifdef CPU_STAT_DISPLAY_DP_EN
    if ((idx_r == sel) && (sel <= SRC_BUB)) begin
      dp_s = 1'b0;
    end else begin
      dp_s = 1'b1;
    end
`else
    dp_s = 1'b1;
`endif
  end

  hex7seg u_hex7seg (
    .nibble (nibble_s),
    .segs   (hex_s)
  );

  // Syscall LED value latch
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_r <= 32'h0;
    end else if (led_cpu_enable) begin
      led_r <= led_data_in;
    end else begin
      led_r <= led_r;
    end
  end

  // Digit-scan prescaler and digit index; keep running while frozen
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_r <= '0;
      idx_r   <= 3'd0;
    end else begin
      presc_r <= presc_r + {{(SCAN_BITS-1){1'b0}}, 1'b1};
      if (tick_s) begin
        idx_r <= idx_r + 3'd1;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Frame snapshot; samples the pre-edge led_r, so a simultaneous strobe lands next frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_r <= 32'h0;
    end else if (snap_load_s) begin
      snap_r <= src_s;
    end else begin
      snap_r <= snap_r;
    end
  end

  // Registered display drive, one cycle behind idx_r and snap_r
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_r  <= AN_RST;
      seg_r <= SEG_RST;
    end else begin
      an_r  <= digit_enable(idx_r);
      seg_r <= {dp_s, hex_s};
    end
  end

  assign an          = an_r;
  assign seg         = seg_r;
  assign shown_value = snap_r;

endmodule

// File: doc/cpu_stat_display.md
# cpu_stat_display

Board-facing output stage that sits directly downstream of the pipelined CPU. It consumes the CPU's syscall LED value (`led_data_in` qualified by `led_cpu_enable`) and its performance counters: total cycles, unconditional branches, conditional branches and bubbles. It selects one of these 32-bit values and drives an 8-digit, time-multiplexed, active-low seven-segment display as hexadecimal. A tear-free snapshot is loaded once per scan frame.

## Interface
Parameters:
- `SCAN_BITS`, default 17: prescaler width; each digit is lit for 2^SCAN_BITS cycles.

Ports:
- `clk`  in  1  system clock, shared with the CPU
- `rst`  in  1  reset, synchronous, active-low
- `led_cpu_enable`  in  1  syscall display strobe from the CPU
- `led_data_in`  in  32  syscall display value from the CPU
- `total_cycles`  in  32  CPU cycle counter
- `uncondi_branch_num`  in  32  unconditional branch counter
- `condi_branch_num`  in  32  conditional branch taken counter
- `bubble_num`  in  32  load-use bubble counter
- `sel`  in  3  display source select
- `freeze`  in  1  hold the current snapshot
- `an`  out  8  digit enables, active-low; bit i = digit i, digit 0 = least significant nibble
- `seg`  out  8  {dp,g,f,e,d,c,b,a}, active-low
- `shown_value`  out  32  current snapshot, for debug and bench

## Operation
- **led_reg (32b).** Loads `led_data_in` on any edge with `led_cpu_enable`=1. Otherwise holds. Reset value 0.
- **Source mux (combinational).**
  - `sel` 0 → led_reg
  - `sel` 1 → `total_cycles`
  - `sel` 2 → `uncondi_branch_num`
  - `sel` 3 → `condi_branch_num`
  - `sel` 4 → `bubble_num`
  - `sel` 5–7 → 32'h0
- **Prescaler (SCAN_BITS b).** Counts up every cycle and wraps at all-ones. `tick` = prescaler at all-ones.
- **Digit index `idx` (3b).** Increments on `tick` and wraps from 7 to 0. A frame is 8 ticks.
- **Snapshot.** Loads the mux output on the edge where `tick`=1, `idx`=7 and `freeze`=0. `shown_value` is this register.
  - `freeze`=1 at that edge: snapshot holds.
  - The prescaler and `idx` continue regardless of `freeze`.
- **Outputs (registered every cycle).**
  - `an` <= ~(8'b1 << `idx`).
  - `seg[6:0]` <= hex7 of snapshot nibble `idx`.
  - `seg[7]` per Configuration.
- **Hex decode, active-low {g..a}:** 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- **Simultaneous events.** A `led_cpu_enable` pulse on the snapshot edge is not seen by that snapshot, because the snapshot samples the old led_reg. It appears in the next frame.

## Timing
- **Reset values** (`rst`=0 at an edge): prescaler 0, `idx` 0, led_reg 0, snapshot 0, `an`=8'hFF, `seg`=8'hFF.
- **First cycle after reset release:** `an`=8'hFE, `seg`=8'hC0 (digit 0 shows "0").
- **`an`/`seg` latency:** one cycle behind `idx` and snapshot.
- **Snapshot latency:** a new source value appears on `shown_value` at most 8·2^SCAN_BITS cycles after it is stable, plus 1 cycle. It appears on `seg` one cycle after that.
- **Reset mid-frame:** all state returns to reset values on that edge. No partial frame is preserved.
- **`sel` changes:** may change at any cycle. Only the value sampled at the snapshot edge is used.

## Configuration
- **`CPU_STAT_DISPLAY_DP_EN` defined:** `seg[7]` <= 0 (lit) when `idx` == `sel` and `sel` ≤ 4. Otherwise 1. The lit point marks the active source on the digit whose number equals `sel`.
- **Not defined:** `seg[7]` is constant 1 (dark), including during reset.

## Structure
- **Package `cpu_stat_pkg`:**
  - Source-select localparams `SRC_LED`=0, `SRC_CYC`=1, `SRC_UBR`=2, `SRC_CBR`=3, `SRC_BUB`=4.
  - Digit count 8.
  - Reset constants for `an`/`seg` (8'hFF).
- **Sub-module `hex7seg`:** combinational, 4b nibble in, 7b active-low {g..a} out. Instantiated once, fed by the nibble mux.

## Test plan
All scenarios run with `SCAN_BITS`=2, so a frame is 32 cycles.
1. Hold `rst`=0 for 3 cycles → `an`=FF, `seg`=FF, `shown_value`=0. After release → `an`=FE, `seg[6:0]`=40.
2. `sel`=0; pulse `led_cpu_enable` with `led_data_in`=32'h12345678 → `shown_value`=12345678 within 33 cycles. While `an`=FE: `seg[6:0]`=00 ("8"). While `an`=7F: `seg[6:0]`=79 ("1").
3. `sel`=2, `uncondi_branch_num`=32'hAB → after the next snapshot, `shown_value`=000000AB. Digit 1 `seg[6:0]`=08. Digit 0 `seg[6:0]`=03. With `CPU_STAT_DISPLAY_DP_EN`: `seg[7]`=0 only while `an`=FB.
4. `freeze`=1, then change `total_cycles` with `sel`=1 → `shown_value` unchanged for 3 frames. Release `freeze` → new value within one frame.
5. `sel`=6 → `shown_value`=0 after the snapshot. Every digit `seg[6:0]`=40.
6. Assert `rst`=0 with `idx`=5 mid-frame → next edge: `an`=FF, `seg`=FF, `shown_value`=0, and the scan restarts at digit 0.
